// File: rtl/ulpi_pkg.sv
// Shared ULPI definitions: arbiter FSM encoding, register addresses and the
// default register-access timeout.
package ulpi_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } state_e;

    typedef enum logic {
        GntA = 1'b0,
        GntB = 1'b1
    } gnt_e;

    localparam logic [7:0] FUNCT_CTL = 8'h04;
    localparam logic [7:0] OTG_CTL   = 8'h0A;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/ulpi_reg_arbiter.sv
// Two-requester round-robin arbiter for the ULPI register access port, with a
// bounded wait for reg_rdy and per-requester ack/err/read-data reporting.
module ulpi_reg_arbiter
    import ulpi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       a_req,
    input  logic       a_we,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_din,
    output logic       a_ack,
    output logic       a_err,
    output logic [7:0] a_dout,

    input  logic       b_req,
    input  logic       b_we,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_din,
    output logic       b_ack,
    output logic       b_err,
    output logic [7:0] b_dout,

    output logic       reg_en,
    output logic       reg_we,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_din,
    input  logic       reg_rdy,
    input  logic [7:0] reg_dout,

    output logic       busy
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    gnt_e            gnt_q, gnt_d;
    logic            we_q, we_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      din_q, din_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_nxt;
    logic            err_q, err_d;
    logic [7:0]      a_dout_q, a_dout_d;
    logic [7:0]      b_dout_q, b_dout_d;

    assign cnt_nxt = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        a_dout_d = a_dout_q;
        b_dout_d = b_dout_q;

        unique case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    // On a tie the requester not served last wins; gnt_q doubles as last-grant.
                    if (a_req && b_req) begin
                        gnt_d = (gnt_q == GntA) ? GntB : GntA;
                    end else begin
                        gnt_d = a_req ? GntA : GntB;
                    end
                    if (gnt_d == GntA) begin
                        we_d   = a_we;
                        addr_d = a_addr;
                        din_d  = a_din;
                    end else begin
                        we_d   = b_we;
                        addr_d = b_addr;
                        din_d  = b_din;
                    end
                    err_d   = 1'b0;
                    state_d = StIssue;
                end
            end

            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end

            StWait: begin
                if (reg_rdy) begin
                    err_d   = 1'b0;
                    state_d = StDone;
                    if (gnt_q == GntA) begin
                        a_dout_d = reg_dout;
                    end else begin
                        b_dout_d = reg_dout;
                    end
                end else if (cnt_nxt >= CntLast) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            gnt_q    <= GntB;
            we_q     <= 1'b0;
            addr_q   <= 8'h00;
            din_q    <= 8'h00;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            a_dout_q <= 8'h00;
            b_dout_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            a_dout_q <= a_dout_d;
            b_dout_q <= b_dout_d;
        end
    end

    assign reg_en   = (state_q == StIssue);
    assign reg_we   = (state_q == StIssue) && we_q;
    assign reg_addr = addr_q;
    assign reg_din  = din_q;
    assign busy     = (state_q != StIdle);

    assign a_ack  = (state_q == StDone) && (gnt_q == GntA);
    assign b_ack  = (state_q == StDone) && (gnt_q == GntB);
    assign a_err  = a_ack && err_q;
    assign b_err  = b_ack && err_q;
    assign a_dout = a_dout_q;
    assign b_dout = b_dout_q;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Directed bench for ulpi_reg_arbiter: single accesses, round-robin ties,
// timeout abort, rdy on the timeout cycle and reset mid-transaction.
module tb_ulpi_reg_arbiter;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_din, b_addr, b_din;
    logic       a_ack, a_err, b_ack, b_err;
    logic [7:0] a_dout, b_dout;
    logic       reg_en, reg_we, reg_rdy;
    logic [7:0] reg_addr, reg_din, reg_dout;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int en_cnt = 0, a_ack_cnt = 0, b_ack_cnt = 0;

    always #5 clk = ~clk;

    ulpi_reg_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_din    (a_din),
        .a_ack    (a_ack),
        .a_err    (a_err),
        .a_dout   (a_dout),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_din    (b_din),
        .b_ack    (b_ack),
        .b_err    (b_err),
        .b_dout   (b_dout),
        .reg_en   (reg_en),
        .reg_we   (reg_we),
        .reg_addr (reg_addr),
        .reg_din  (reg_din),
        .reg_rdy  (reg_rdy),
        .reg_dout (reg_dout),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (reg_en) en_cnt++;
        if (a_ack) a_ack_cnt++;
        if (b_ack) b_ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input string tag);
        for (int i = 0; i < 50 && !reg_en; i++) tick();
        check(tag, 32'(reg_en), 1);
    endtask

    int en0, aa0, ba0, cyc;
    logic [7:0] exp_addr[4];

    initial begin
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_din = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_din = 0;
        reg_rdy = 0; reg_dout = 0;
        #12;
        check("rst busy", 32'(busy), 0);
        check("rst reg_en", 32'(reg_en), 0);
        check("rst a_ack", 32'(a_ack), 0);
        check("rst a_dout", 32'(a_dout), 0);
        check("rst b_dout", 32'(b_dout), 0);
        check("rst reg_addr", 32'(reg_addr), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // A write to FUNCT_CTL, rdy three cycles after reg_en
        en0 = en_cnt; aa0 = a_ack_cnt; ba0 = b_ack_cnt;
        a_req = 1; a_we = 1; a_addr = 8'h04; a_din = 8'h45;
        tick();
        check("wr reg_en", 32'(reg_en), 1);
        check("wr reg_we", 32'(reg_we), 1);
        check("wr reg_addr", 32'(reg_addr), 'h04);
        check("wr reg_din", 32'(reg_din), 'h45);
        check("wr busy", 32'(busy), 1);
        tick();
        check("wr en drop", 32'(reg_en), 0);
        check("wr we drop", 32'(reg_we), 0);
        tick();
        tick();
        reg_rdy = 1; reg_dout = 8'h33;
        tick();
        reg_rdy = 0;
        check("wr a_ack", 32'(a_ack), 1);
        check("wr a_err", 32'(a_err), 0);
        check("wr b_ack", 32'(b_ack), 0);
        check("wr a_dout", 32'(a_dout), 'h33);
        a_req = 0;
        tick();
        check("wr idle busy", 32'(busy), 0);
        check("wr ack drop", 32'(a_ack), 0);
        check("wr addr hold", 32'(reg_addr), 'h04);
        check("wr en count", 32'(en_cnt - en0), 1);
        check("wr a_ack count", 32'(a_ack_cnt - aa0), 1);
        check("wr b_ack count", 32'(b_ack_cnt - ba0), 0);

        // B read of OTG_CTL
        b_req = 1; b_we = 0; b_addr = 8'h0A; b_din = 8'h00;
        tick();
        check("rd reg_en", 32'(reg_en), 1);
        check("rd reg_we", 32'(reg_we), 0);
        check("rd reg_addr", 32'(reg_addr), 'h0A);
        tick();
        reg_rdy = 1; reg_dout = 8'h5A;
        tick();
        reg_rdy = 0;
        check("rd b_ack", 32'(b_ack), 1);
        check("rd a_ack", 32'(a_ack), 0);
        check("rd b_dout", 32'(b_dout), 'h5A);
        check("rd a_dout hold", 32'(a_dout), 'h33);
        b_req = 0;
        tick();

        // Both requesting continuously: A,B,A,B
        exp_addr[0] = 8'h04; exp_addr[1] = 8'h0A; exp_addr[2] = 8'h04; exp_addr[3] = 8'h0A;
        a_req = 1; a_we = 0; a_addr = 8'h04;
        b_req = 1; b_we = 0; b_addr = 8'h0A;
        for (int i = 0; i < 4; i++) begin
            wait_en($sformatf("rr%0d en", i));
            check($sformatf("rr%0d grant addr", i), 32'(reg_addr), 32'(exp_addr[i]));
            tick();
            reg_rdy = 1; reg_dout = 8'h10 + 8'(i);
            tick();
            reg_rdy = 0;
            if (i % 2 == 0) begin
                check($sformatf("rr%0d a_ack", i), 32'(a_ack), 1);
                check($sformatf("rr%0d a_dout", i), 32'(a_dout), 32'('h10 + i));
            end else begin
                check($sformatf("rr%0d b_ack", i), 32'(b_ack), 1);
                check($sformatf("rr%0d b_dout", i), 32'(b_dout), 32'('h10 + i));
            end
            if (i == 3) begin
                a_req = 0; b_req = 0;
            end
            tick();
        end

        // Timeout: no reg_rdy at all
        a_req = 1; a_we = 0; a_addr = 8'h04;
        wait_en("to en");
        cyc = 0;
        while (!a_ack && cyc < 40) begin
            tick();
            cyc++;
        end
        check("to cycles", 32'(cyc), 16);
        check("to a_ack", 32'(a_ack), 1);
        check("to a_err", 32'(a_err), 1);
        check("to b_ack", 32'(b_ack), 0);
        check("to a_dout hold", 32'(a_dout), 'h12);
        a_req = 0;
        tick();
        check("to busy fall", 32'(busy), 0);
        check("to err drop", 32'(a_err), 0);

        // reg_rdy on the timeout cycle wins
        a_req = 1; a_we = 0; a_addr = 8'h0A;
        wait_en("rt en");
        repeat (15) tick();
        check("rt still waiting", 32'(a_ack), 0);
        reg_rdy = 1; reg_dout = 8'hC3;
        tick();
        reg_rdy = 0;
        check("rt a_ack", 32'(a_ack), 1);
        check("rt a_err", 32'(a_err), 0);
        check("rt a_dout", 32'(a_dout), 'hC3);
        a_req = 0;
        tick();

        // Reset while in WAIT (last grant was A, so a tie would favour B without reset)
        a_req = 1; a_we = 1; a_addr = 8'h04; a_din = 8'h77;
        wait_en("rs en");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rs busy", 32'(busy), 0);
        check("rs reg_en", 32'(reg_en), 0);
        check("rs a_dout", 32'(a_dout), 0);
        check("rs b_dout", 32'(b_dout), 0);
        check("rs reg_addr", 32'(reg_addr), 0);
        a_req = 0;
        tick();
        rst_n = 1'b1;
        aa0 = a_ack_cnt;
        repeat (5) tick();
        check("rs no ack", 32'(a_ack_cnt - aa0), 0);
        check("rs idle", 32'(busy), 0);
        a_req = 1; a_we = 0; a_addr = 8'h04;
        b_req = 1; b_we = 0; b_addr = 8'h0A;
        wait_en("rs tie en");
        check("rs tie A wins", 32'(reg_addr), 'h04);
        tick();
        reg_rdy = 1; reg_dout = 8'h99;
        tick();
        reg_rdy = 0;
        check("rs tie a_ack", 32'(a_ack), 1);
        a_req = 0; b_req = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
